// File: rtl/lc3_dmem_responder.sv
// Data-memory responder for the LC3 MemAccess stage: writes complete at once, reads answer after RD_LATENCY cycles.
// Optional macro DMEM_ADDR_CHECK_EN: rejects requests whose address has nonzero bits at or above ADDR_BITS.
module lc3_dmem_responder #(
   parameter int ADDR_BITS  = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        dmem_en,
   input  logic        DMem_rd,
   input  logic [15:0] DMem_addr,
   input  logic [15:0] DMem_din,
   output logic [15:0] DMem_dout,
   output logic        dout_valid,
   output logic        busy,
   output logic        addr_err
);

   if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
      $error("lc3_dmem_responder: RD_LATENCY must be in 1..8");
   end

   localparam logic [2:0] LAST_COUNT = 3'(RD_LATENCY - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                 state;
   logic [2:0]             count;
   logic [ADDR_BITS-1:0]   addr_q;
   logic                   err_q;
   logic                   accept;
   logic                   range_bad;
   logic [15:0]            mem [0:(1 << ADDR_BITS) - 1];

   // Handshake: a request is taken on any rising edge where dmem_en=1 and the
   // responder is idle; there is no backpressure, so requests seen while busy
   // are simply dropped.
   assign accept = dmem_en && (state == IDLE);
   assign busy   = (state == WAIT);

`ifdef DMEM_ADDR_CHECK_EN
   assign range_bad = ((DMem_addr >> ADDR_BITS) != 16'd0);
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^(DMem_addr >> ADDR_BITS);
   assign range_bad      = 1'b0;
`endif

   // Array has no reset so contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (reset && accept && !DMem_rd && !range_bad)
         mem[DMem_addr[ADDR_BITS-1:0]] <= DMem_din;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= 3'd0;
         addr_q     <= '0;
         err_q      <= 1'b0;
         DMem_dout  <= 16'h0000;
         dout_valid <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         addr_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (dmem_en) begin
                  if (DMem_rd) begin
                     addr_q <= DMem_addr[ADDR_BITS-1:0];
                     err_q  <= range_bad;
                     count  <= LAST_COUNT;
                     state  <= WAIT;
                  end else begin
                     addr_err <= range_bad;
                  end
               end
            end
            WAIT: begin
               if (count == 3'd0) begin
                  DMem_dout  <= err_q ? 16'hDEAD : mem[addr_q];
                  dout_valid <= 1'b1;
                  addr_err   <= err_q;
                  state      <= IDLE;
               end else begin
                  count <= count - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Bench for lc3_dmem_responder: timeline reference model feeds an expected queue, a monitor checks every cycle.
// Honours DMEM_ADDR_CHECK_EN the same way the design does.
module tb_lc3_dmem_responder;

   localparam int LAT = 4;
   localparam int AB  = 8;
   localparam int W   = 50;   // {due_edge[31:0], data[15:0], err, is_response}

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        dmem_en = 1'b0;
   logic        DMem_rd = 1'b0;
   logic [15:0] DMem_addr = 16'h0;
   logic [15:0] DMem_din = 16'h0;
   logic [15:0] DMem_dout;
   logic        dout_valid;
   logic        busy;
   logic        addr_err;

   always #5 clock = ~clock;

   lc3_dmem_responder #(.ADDR_BITS(AB), .RD_LATENCY(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .dmem_en    (dmem_en),
      .DMem_rd    (DMem_rd),
      .DMem_addr  (DMem_addr),
      .DMem_din   (DMem_din),
      .DMem_dout  (DMem_dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .addr_err   (addr_err)
   );

   int edge_cnt = 0;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   // Reference model: word array plus the earliest edge at which a new request is taken.
   logic [15:0]  mem_m [256];
   int           free_edge = 0;
   logic [15:0]  model_dout = 16'h0;
   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   bit           mon_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic issue(input logic rd, input logic [15:0] addr, input logic [15:0] din);
      int   e;
      logic oor;
      @(negedge clock);
      dmem_en   = 1'b1;
      DMem_rd   = rd;
      DMem_addr = addr;
      DMem_din  = din;
      e = edge_cnt + 1;
      if (e >= free_edge) begin
         oor = 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
         oor = (addr >> AB) != 16'd0;
`endif
         if (rd) begin
            exp_q.push_back({32'(e + LAT), (oor ? 16'hDEAD : mem_m[addr[AB-1:0]]), oor, 1'b1});
            free_edge = e + LAT + 1;
         end else if (oor) begin
            exp_q.push_back({32'(e), 16'h0000, 1'b1, 1'b0});
         end else begin
            mem_m[addr[AB-1:0]] = din;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         dmem_en   = 1'b0;
         DMem_rd   = 1'($urandom);
         DMem_addr = 16'($urandom);
         DMem_din  = 16'($urandom);
      end
   endtask

   task automatic do_reset();
      @(posedge clock);
      #3;
      reset   = 1'b0;
      dmem_en = 1'b0;
      exp_q.delete();
      model_dout = 16'h0000;
      free_edge  = 0;
      #1;
      check("rst_dout", 32'(DMem_dout), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_addr_err", 32'(addr_err), 32'h0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   // Monitor: one sample per cycle, 1 ns after the rising edge.
   initial begin
      int           k;
      logic [W-1:0] ent;
      logic         exp_v;
      logic         exp_e;
      forever begin
         @(posedge clock);
         #1;
         if (mon_on) begin
            k = edge_cnt;
            exp_v = 1'b0;
            exp_e = 1'b0;
            if (exp_q.size() > 0 && exp_q[0][49:18] == 32'(k)) begin
               ent = exp_q.pop_front();
               exp_v = ent[0];
               exp_e = ent[1];
               if (ent[0]) model_dout = ent[17:2];
            end
            check("dout_valid", 32'(dout_valid), 32'(exp_v));
            check("addr_err", 32'(addr_err), 32'(exp_e));
            check("busy", 32'(busy), 32'(free_edge - 1 > k));
            check("DMem_dout", 32'(DMem_dout), 32'(model_dout));
         end
      end
   end

   initial begin
      logic [15:0] addr;
      #3;
      reset = 1'b0;
      #1;
      check("init_rst_dout", 32'(DMem_dout), 32'h0);
      check("init_rst_valid", 32'(dout_valid), 32'h0);
      check("init_rst_busy", 32'(busy), 32'h0);
      check("init_rst_addr_err", 32'(addr_err), 32'h0);
      mon_on = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Fill the whole array with back-to-back writes so every read has a known value.
      for (int a = 0; a < 256; a++) issue(1'b0, 16'(a), 16'($urandom));

      // Write then read on the very next edge.
      issue(1'b0, 16'h0010, 16'h1234);
      issue(1'b1, 16'h0010, 16'h0);
      idle(LAT + 1);
      issue(1'b0, 16'h0005, 16'hBEEF);
      issue(1'b1, 16'h0005, 16'h0);
      idle(LAT + 1);

      // Write issued while a read is outstanding must be dropped.
      issue(1'b1, 16'h0005, 16'h0);
      issue(1'b0, 16'h0005, 16'h0000);
      idle(LAT + 1);
      issue(1'b1, 16'h0005, 16'h0);
      idle(LAT + 1);

      // Reset two cycles into a read: response discarded, memory retained.
      issue(1'b1, 16'h0005, 16'h0);
      idle(2);
      do_reset();
      idle(LAT + 2);
      issue(1'b1, 16'h0005, 16'h0);
      idle(LAT + 1);

      // Upper address bits: alias, or rejected when the range check is built in.
      issue(1'b0, 16'h0105, 16'hA5A5);
      idle(1);
      issue(1'b1, 16'h0005, 16'h0);
      idle(LAT + 1);
      issue(1'b1, 16'h0105, 16'h0);
      idle(LAT + 1);

      // Random traffic, including requests that land while busy.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
            issue(1'($urandom_range(0, 1)), addr, 16'($urandom));
         end
         if (i == 300) do_reset();
      end

      idle(LAT + 3);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
